// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM load/store requests into one outstanding req/ack bus transaction.
// It stalls upstream until the access completes, then presents write-back controls for one DONE cycle.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [4:0]  DestReg_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] StoreData_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  DestReg_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] MemRead_data_out,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_q;
  logic             abort_q;

  logic mem_op;
  logic misaligned;
  logic timeout_hit;

  assign mem_op      = MemRead_in | MemWrite_in;
  assign misaligned  = ALU_result_in[1:0] != 2'b00;
  assign timeout_hit = cnt == CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      data_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !misaligned) begin
            // A request with both read and write set is issued as a write.
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_in;
            mem_addr  <= ALU_result_in;
            mem_wdata <= StoreData_in;
            cnt       <= '0;
            abort_q   <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            if (!mem_we) data_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            data_q  <= '0;
            abort_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_out    = 1'b0;
    align_err    = 1'b0;
    bus_err      = 1'b0;
    RegWrite_out = 1'b0;
    case (state)
      IDLE: begin
        stall_out    = mem_op && !misaligned;
        align_err    = mem_op && misaligned;
        RegWrite_out = RegWrite_in && !mem_op;
      end
      BUSY: stall_out = 1'b1;
      DONE: begin
        bus_err      = abort_q;
        RegWrite_out = RegWrite_in && !abort_q;
      end
      default: ;
    endcase
  end

  assign MemToReg_out     = MemToReg_in;
  assign DestReg_out      = DestReg_in;
  assign ALU_result_out   = ALU_result_in;
  assign MemRead_data_out = data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases then randomized transactions checked against a per-transaction model.
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
  logic [4:0]  DestReg_in;
  logic [31:0] ALU_result_in, StoreData_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_out, RegWrite_out, MemToReg_out;
  logic [4:0]  DestReg_out;
  logic [31:0] ALU_result_out, MemRead_data_out;
  logic        align_err, bus_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_data = 32'h0;

  mem_stage #(.TIMEOUT(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .DestReg_in(DestReg_in), .ALU_result_in(ALU_result_in), .StoreData_in(StoreData_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .DestReg_out(DestReg_out), .ALU_result_out(ALU_result_out),
    .MemRead_data_out(MemRead_data_out), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] sd);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemToReg_in = m2r;
    DestReg_in = dst; ALU_result_in = alu; StoreData_in = sd;
  endtask

  task automatic chk_pass(input logic m2r, input logic [4:0] dst, input logic [31:0] alu);
    chk("alu_pass", ALU_result_out, alu);
    chk("dest_pass", {27'b0, DestReg_out}, {27'b0, dst});
    chk("m2r_pass", {31'b0, MemToReg_out}, {31'b0, m2r});
  endtask

  // One complete transaction; k is the BUSY cycle carrying the ack, k > T means no ack.
  task automatic txn(input logic rd, input logic wr, input logic rw, input logic m2r,
                     input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] sd,
                     input int k, input logic [31:0] rdata);
    bit is_op, mis, to;
    int n;
    is_op = rd | wr;
    mis = alu[1:0] != 2'b00;
    @(negedge clk);
    set_in(rd, wr, rw, m2r, dst, alu, sd);
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    chk("idle_req", {31'b0, mem_req}, 32'd0);
    chk_pass(m2r, dst, alu);
    chk("idle_data", MemRead_data_out, model_data);
    chk("idle_buserr", {31'b0, bus_err}, 32'd0);
    if (!is_op) begin
      chk("nop_stall", {31'b0, stall_out}, 32'd0);
      chk("nop_regwr", {31'b0, RegWrite_out}, {31'b0, rw});
      chk("nop_align", {31'b0, align_err}, 32'd0);
      return;
    end
    if (mis) begin
      chk("mis_align", {31'b0, align_err}, 32'd1);
      chk("mis_stall", {31'b0, stall_out}, 32'd0);
      chk("mis_regwr", {31'b0, RegWrite_out}, 32'd0);
      return;
    end
    chk("op_stall", {31'b0, stall_out}, 32'd1);
    chk("op_regwr", {31'b0, RegWrite_out}, 32'd0);
    chk("op_align", {31'b0, align_err}, 32'd0);
    to = k > T;
    n = to ? T : k;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      mem_ack = (j == k);
      mem_rdata = (j == k) ? rdata : $urandom;
      #1;
      chk("busy_req", {31'b0, mem_req}, 32'd1);
      chk("busy_we", {31'b0, mem_we}, {31'b0, wr});
      chk("busy_addr", mem_addr, alu);
      chk("busy_wdata", mem_wdata, sd);
      chk("busy_stall", {31'b0, stall_out}, 32'd1);
      chk("busy_regwr", {31'b0, RegWrite_out}, 32'd0);
    end
    if (to) model_data = 32'h0;
    else if (!wr) model_data = rdata;
    @(negedge clk);
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    chk("done_req", {31'b0, mem_req}, 32'd0);
    chk("done_stall", {31'b0, stall_out}, 32'd0);
    chk("done_buserr", {31'b0, bus_err}, {31'b0, to});
    chk("done_regwr", {31'b0, RegWrite_out}, {31'b0, rw & ~to});
    chk("done_data", MemRead_data_out, model_data);
    chk_pass(m2r, dst, alu);
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    set_in(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    #12;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_data", MemRead_data_out, 32'h0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_errs", {30'b0, align_err, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(0, 0, 1, 0, 5'd3, 32'h1234, 32'h0, 1, 32'h0);
    txn(1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 2, 32'hCAFEF00D);
    txn(0, 1, 0, 0, 5'd0, 32'h200, 32'hA5A5A5A5, 1, 32'h0);
    txn(1, 0, 1, 1, 5'd9, 32'h102, 32'h0, 1, 32'h0);
    txn(1, 1, 1, 0, 5'd4, 32'h300, 32'h11112222, 3, 32'h5555AAAA);
    txn(1, 0, 1, 1, 5'd8, 32'h400, 32'h0, T + 2, 32'h0);

    // Reset in the middle of BUSY.
    @(negedge clk);
    set_in(1, 0, 1, 1, 5'd2, 32'h500, 32'h0);
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_data", MemRead_data_out, 32'h0);
    model_data = 32'h0;
    @(negedge clk);
    set_in(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", {31'b0, stall_out}, 32'd0);
    chk("post_rst_req", {31'b0, mem_req}, 32'd0);
    txn(1, 0, 1, 0, 5'd6, 32'h600, 32'h0, 1, 32'h0BADBEEF);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 8) a[1:0] = 2'b00;
      txn(kind != 0 && $urandom_range(0, 1) == 1, kind != 0 && $urandom_range(0, 2) == 0,
          1'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
          $urandom_range(1, T + 2), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM pipeline register and the MEM/WB register. It turns load/store requests from EX/MEM into a single-outstanding request/acknowledge transaction on the data-memory bus. It stalls the upstream pipeline until the access completes, then presents write-back controls, ALU result and load data to MEM/WB for exactly one cycle. It also detects misaligned word accesses and bus timeouts, and squashes the register write when either occurs.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting for mem_ack before abort (≥2)
- CNT_W, 5: timeout counter width; must hold TIMEOUT
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- MemRead_in  in  1  load request from EX/MEM
- MemWrite_in  in  1  store request from EX/MEM
- RegWrite_in  in  1  write-back enable from EX/MEM
- MemToReg_in  in  1  write-back select from EX/MEM
- DestReg_in  in  5  destination register
- ALU_result_in  in  32  effective address / ALU result
- StoreData_in  in  32  store data
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  word address, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  bus completion, single-cycle pulse
- mem_rdata  in  32  read data, valid when mem_ack=1
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- RegWrite_out, MemToReg_out, DestReg_out, ALU_result_out  out  1/1/5/32  to MEM/WB
- MemRead_data_out  out  32  load data to MEM/WB
- align_err  out  1  one-cycle pulse, misaligned access
- bus_err  out  1  one-cycle pulse, timeout

## Operation
- States: IDLE, BUSY, DONE.
- mem_op = MemRead_in | MemWrite_in. misaligned = ALU_result_in[1:0] != 0.
- IDLE, no mem_op:
  - Pass-through to MEM/WB; stall_out = 0.
- IDLE, mem_op and misaligned:
  - No bus request; stall_out = 0.
  - align_err = 1 (combinational, this cycle).
  - RegWrite_out forced 0.
  - Stay in IDLE.
- IDLE, mem_op and aligned:
  - stall_out = 1; RegWrite_out forced 0.
  - Latch mem_addr = ALU_result_in, mem_wdata = StoreData_in, mem_we = MemWrite_in.
  - Set mem_req = 1; clear counter; go to BUSY.
  - If MemRead_in and MemWrite_in are both 1, treat as a write.
- BUSY:
  - stall_out = 1; RegWrite_out forced 0.
  - mem_req, mem_we, mem_addr and mem_wdata held stable.
  - Counter increments each cycle.
  - mem_ack = 1: capture mem_rdata into the data register (loads only), drop mem_req, go to DONE.
  - Counter == TIMEOUT-1 with no ack: drop mem_req, zero the data register, set the abort flag, go to DONE.
  - Ack takes priority over timeout in the same cycle.
- DONE (one cycle):
  - stall_out = 0.
  - Controls pass through from the still-held EX/MEM values; MemRead_data_out = data register.
  - If the abort flag is set: bus_err = 1 and RegWrite_out forced 0.
  - Inputs are not examined for a new op. Next state is IDLE.
- mem_ack outside BUSY is ignored.
- MemRead_data_out always drives the data register, and it is not changed by stores.
- ALU_result_out, DestReg_out and MemToReg_out are always combinational pass-through.

## Timing
- Reset, asynchronous:
  - State IDLE, mem_req/mem_we = 0, mem_addr/mem_wdata = 0.
  - Data register = 0, counter = 0, abort flag = 0.
  - align_err/bus_err = 0.
  - stall_out follows the IDLE rule.
- Reset in BUSY aborts the transaction immediately: mem_req falls asynchronously, and no DONE cycle occurs.
- Aligned access with ack on the k-th BUSY cycle (k ≥ 1):
  - stall_out high for k+1 cycles, DONE on cycle k+1.
  - MEM/WB latches at the end of DONE.
  - Minimum total latency is 3 cycles from the op appearing.
- mem_req rises 1 cycle after the op is presented.
- Timeout: DONE occurs TIMEOUT+1 cycles after the op appears.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after DONE, with no dead cycle.

## Test plan
- Non-memory op, RegWrite_in = 1, ALU_result_in = 0x1234 → same cycle: stall_out = 0, RegWrite_out = 1, ALU_result_out = 0x1234, mem_req stays 0.
- Load from 0x100, ack after 2 BUSY cycles with rdata = 0xCAFEF00D:
  - stall_out high for 3 cycles.
  - DONE: MemRead_data_out = 0xCAFEF00D, RegWrite_out = 1.
  - mem_addr held at 0x100 throughout BUSY.
- Store of 0xA5A5A5A5 to 0x200 with immediate ack → mem_we = 1, mem_wdata = 0xA5A5A5A5 while mem_req is high; MemRead_data_out unchanged.
- Load from 0x102 → align_err pulses 1 cycle, RegWrite_out = 0, stall_out = 0, mem_req never rises.
- Load with TIMEOUT = 4 and no ack → mem_req high for 4 cycles; DONE has bus_err = 1, RegWrite_out = 0, MemRead_data_out = 0.
- Reset asserted mid-BUSY → mem_req falls with no clock edge; after release, state is IDLE and a fresh load completes normally.
